// File: rtl/codif_bin_a_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter blocks.
//   state_e  : converter FSM encoding (IDLE=0, CONV=1, FIN=2)
//   ITER_MAX : last value of the iteration counter (one step per input bit)
//   CNT_W    : iteration counter width
//   SAT_BCD  : saturated result returned for values above 99
package codif_bin_a_bcd_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StConv = 2'd1,
    StFin  = 2'd2
  } state_e;

  localparam int unsigned ITER_MAX = 6;
  localparam int unsigned CNT_W    = $clog2(ITER_MAX + 1);
  localparam logic [7:0]  SAT_BCD  = 8'h99;

endpackage

// File: rtl/codif_bin_a_bcd_if.sv
// Request/result bundle for codif_bin_a_bcd.
//   start   : conversion request (master -> slave)
//   bin_in  : unsigned binary value (master -> slave)
//   bcd_out : packed BCD result, [7:4] tens, [3:0] units (slave -> master)
//   ovf     : accepted value was above 99 (slave -> master)
//   busy    : converter not idle (slave -> master)
//   done    : one-cycle completion pulse (slave -> master)
interface codif_bin_a_bcd_if #(
  parameter int unsigned ANCHO_BIN = 7,
  parameter int unsigned ANCHO_BCD = 8
) ();

  logic                 start;
  logic [ANCHO_BIN-1:0] bin_in;
  logic [ANCHO_BCD-1:0] bcd_out;
  logic                 ovf;
  logic                 busy;
  logic                 done;

  modport master (
    output start,
    output bin_in,
    input  bcd_out,
    input  ovf,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  bin_in,
    output bcd_out,
    output ovf,
    output busy,
    output done
  );

endinterface

// File: rtl/ajuste_mas3.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more,
// so the following left shift carries into the next digit.
//   din_i  : BCD nibble before correction
//   dout_o : corrected nibble
module ajuste_mas3 (
  input  logic [3:0] din_i,
  output logic [3:0] dout_o
);

  always_comb begin
    dout_o = din_i;
    if (din_i >= 4'd5) begin
      dout_o = din_i + 4'd3;
    end
  end

endmodule

// File: rtl/codif_bin_a_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Accepts a value when idle and start is high, runs ITER_MAX+1 double-dabble
// steps, then registers a two-digit BCD result (saturated to 99 with ovf set
// when the value exceeds 99) and pulses done for one cycle.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of codif_bin_a_bcd_if (start/bin_in in, results out)
module codif_bin_a_bcd
  import codif_bin_a_bcd_pkg::*;
#(
  parameter int unsigned ANCHO_BIN = 7,
  parameter int unsigned ANCHO_BCD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  codif_bin_a_bcd_if.slave  bus
);

  state_e               state_q, state_d;
  logic [ANCHO_BIN-1:0] shift_q, shift_d;
  logic [ANCHO_BCD-1:0] scratch_q, scratch_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 carry_q, carry_d;
  logic [ANCHO_BCD-1:0] bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic [3:0]           units_adj, tens_adj;
  logic [ANCHO_BCD-1:0] adj;
  logic                 step_carry;
  logic [ANCHO_BCD-1:0] step_scratch;
  logic [ANCHO_BIN-1:0] step_shift;
  logic                 hundreds;

  ajuste_mas3 u_adj_units (
    .din_i  (scratch_q[3:0]),
    .dout_o (units_adj)
  );

  ajuste_mas3 u_adj_tens (
    .din_i  (scratch_q[7:4]),
    .dout_o (tens_adj)
  );

  assign adj = {tens_adj, units_adj};

  // One double-dabble step: corrected digits and the binary shift register
  // move left together; the bit leaving the tens digit is a hundreds digit.
  assign {step_carry, step_scratch, step_shift} = {adj, shift_q, 1'b0};

  // Hundreds are never stored; any carry out of the tens digit (now or in an
  // earlier step) or an out-of-range tens digit means the value is above 99.
  assign hundreds = carry_q | step_carry | (step_scratch[7:4] > 4'd9);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          shift_d   = bus.bin_in;
          scratch_d = '0;
          cnt_d     = '0;
          carry_d   = 1'b0;
          state_d   = StConv;
        end
      end
      StConv: begin
        shift_d   = step_shift;
        scratch_d = step_scratch;
        carry_d   = carry_q | step_carry;
        if (cnt_q == CNT_W'(ITER_MAX)) begin
          bcd_d   = hundreds ? SAT_BCD : step_scratch;
          ovf_d   = hundreds;
          done_d  = 1'b1;
          state_d = StFin;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // busy is registered from the next state so it tracks state_q exactly.
  assign busy_d = (state_d != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.bcd_out = bcd_q;
  assign bus.ovf     = ovf_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_codif_bin_a_bcd.sv
// Bench for codif_bin_a_bcd: table of directed conversions, continuous-start,
// mid-conversion reset and a full 0..127 sweep against a decimal model.
module tb_codif_bin_a_bcd;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [7:0] prev_bcd;

  codif_bin_a_bcd_if #(.ANCHO_BIN(7), .ANCHO_BCD(8)) bus ();

  codif_bin_a_bcd #(.ANCHO_BIN(7), .ANCHO_BCD(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] bin;
    logic [7:0] bcd;
    logic       ovf;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_bcd(input int v);
    if (v > 99) return 8'h99;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seq_val(input int c);
    return 7'((c * 11 + 7) % 128);
  endfunction

  // Called at a negedge with the converter idle; returns at a negedge, idle.
  task automatic run_conv(input logic [6:0] v, input logic [7:0] exp_bcd,
                          input logic exp_ovf, input string tag);
    int lat;
    lat = 0;
    bus.start  = 1'b1;
    bus.bin_in = v;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.bin_in = ~v;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 4) begin
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        check({tag, "_hold"}, {24'd0, bus.bcd_out}, {24'd0, prev_bcd});
      end
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clk);
    end
    check({tag, "_latency"}, lat, 32'd8);
    check({tag, "_bcd"}, {24'd0, bus.bcd_out}, {24'd0, exp_bcd});
    check({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, exp_ovf});
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_low"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    prev_bcd = exp_bcd;
  endtask

  initial begin
    int seen;
    checks = 0;
    errors = 0;
    prev_bcd = 8'h00;

    vecs[0]  = '{7'd57,  8'h57, 1'b0};
    vecs[1]  = '{7'd0,   8'h00, 1'b0};
    vecs[2]  = '{7'd99,  8'h99, 1'b0};
    vecs[3]  = '{7'd9,   8'h09, 1'b0};
    vecs[4]  = '{7'd10,  8'h10, 1'b0};
    vecs[5]  = '{7'd100, 8'h99, 1'b1};
    vecs[6]  = '{7'd127, 8'h99, 1'b1};
    vecs[7]  = '{7'd42,  8'h42, 1'b0};
    vecs[8]  = '{7'd73,  8'h73, 1'b0};
    vecs[9]  = '{7'd64,  8'h64, 1'b0};
    vecs[10] = '{7'd85,  8'h85, 1'b0};
    vecs[11] = '{7'd1,   8'h01, 1'b0};

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bin_in = 7'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_bcd", {24'd0, bus.bcd_out}, 32'd0);
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf, $sformatf("vec%0d", i));
    end

    // start held high: accepts at edges 0, 9, 18, 27; done seen before 8, 17, 26, 35
    for (int c = 0; c <= 37; c++) begin
      if (c > 0) begin
        logic exp_done;
        exp_done = (c == 8) || (c == 17) || (c == 26) || (c == 35);
        check($sformatf("cont_done_c%0d", c), {31'd0, bus.done}, {31'd0, exp_done});
        if (exp_done) begin
          check($sformatf("cont_bcd_c%0d", c), {24'd0, bus.bcd_out},
                {24'd0, model_bcd(int'(seq_val(c - 8)))});
          check($sformatf("cont_ovf_c%0d", c), {31'd0, bus.ovf},
                {31'd0, (seq_val(c - 8) > 7'd99)});
        end
      end
      bus.start  = (c <= 27);
      bus.bin_in = seq_val(c);
      @(posedge clk);
      @(negedge clk);
    end
    bus.start = 1'b0;
    prev_bcd  = model_bcd(int'(seq_val(27)));

    // Reset in the 4th CONV cycle of a 73 conversion
    bus.start  = 1'b1;
    bus.bin_in = 7'd73;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_bcd", {24'd0, bus.bcd_out}, 32'd0);
    check("abort_ovf", {31'd0, bus.ovf}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) seen++;
    end
    check("abort_no_done", seen, 32'd0);
    prev_bcd = 8'h00;
    run_conv(7'd73, 8'h73, 1'b0, "after_abort");

    for (int v = 0; v < 128; v++) begin
      run_conv(7'(v), model_bcd(v), (v > 99), $sformatf("sweep%0d", v));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/codif_bin_a_bcd.md
CODIF_BIN_A_BCD -- requirements
Module: codif_bin_a_bcd

Interface
REQ-001 SHALL have parameter ANCHO_BIN, default 7, binary input width.
REQ-002 SHALL have parameter ANCHO_BCD, default 8, packed BCD output width (two digits).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, conversion request, sampled only in IDLE.
REQ-006 SHALL have port bin_in, input, 7, unsigned binary value, sampled on the accepting edge only.
REQ-007 SHALL have port bcd_out, output, 8, result: [7:4] tens, [3:0] units.
REQ-008 SHALL have port ovf, output, 1, set when the accepted value exceeds 99.
REQ-009 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-010 SHALL have port done, output, 1, single-cycle completion pulse.

Function
REQ-011 SHALL implement an FSM with states IDLE, CONV and FIN.
REQ-012 SHALL leave IDLE only when start=1 at a clock edge: load bin_in into the shift register, clear the 8-bit BCD scratch register and iteration counter, and go to CONV.
REQ-013 SHALL perform one double-dabble step per CONV cycle: each scratch nibble >= 5 gets +3, then the combined {scratch, shift register} shifts left by 1.
REQ-014 SHALL stay in CONV for exactly 7 edges; on the 7th (counter = 6) it SHALL latch the result into bcd_out and ovf, then go to FIN.
REQ-015 SHALL assert done for exactly the one FIN cycle, which is 8 edges after the accepting edge, then return to IDLE on the next edge.
REQ-016 SHALL, for bin_in 0..99, produce the exact two-digit BCD value with ovf=0.
REQ-017 SHALL, for bin_in 100..127, produce bcd_out = 8'h99 (saturated) with ovf=1; the hundreds carry is detected from the shift carry-out or tens >= 10.
REQ-018 SHALL ignore start while busy=1, including during FIN; minimum start-to-start spacing is 9 cycles.
REQ-019 SHALL hold bcd_out and ovf stable from the latching edge until the next conversion's latching edge.
REQ-020 SHALL ignore bin_in changes after the accepting edge.

Reset
REQ-021 SHALL, on rst_n low (asynchronous, any state, including mid-CONV), force state = IDLE, bcd_out = 8'h00, ovf = 0, done = 0, busy = 0, and clear the counter and scratch registers.
REQ-022 SHALL, after rst_n deasserts, act on the first start seen at a rising edge; a conversion aborted by reset SHALL NOT produce a done pulse.

Structure
REQ-023 SHALL take the state encodings (IDLE=2'd0, CONV=2'd1, FIN=2'd2), ITER_MAX=6 and SAT_BCD=8'h99 from the shared package/include for the BCD blocks.
REQ-024 SHALL instantiate a combinational sub-module ajuste_mas3 (4-bit in, 4-bit out: in+3 if in>=5, else in), once per digit.
REQ-025 SHALL keep all outputs registered; no combinational path from inputs to outputs.

Verification
REQ-026 SHALL cover: start with bin_in=57 -> done exactly 8 cycles after the accepting edge, bcd_out=8'h57, ovf=0.
REQ-027 SHALL cover: bin_in=0 -> 8'h00; bin_in=99 -> 8'h99, ovf=0; bin_in=9 -> 8'h09; bin_in=10 -> 8'h10.
REQ-028 SHALL cover: bin_in=100 and bin_in=127 -> bcd_out=8'h99, ovf=1; then bin_in=42 -> 8'h42, ovf=0.
REQ-029 SHALL cover: start=1 held continuously with bin_in changing each cycle -> only the values at accepting edges convert; done pulses are 9 cycles apart.
REQ-030 SHALL cover: rst_n pulsed low in the 4th CONV cycle of a 73 conversion -> outputs are immediately 0/IDLE, no done, and the next start with 73 gives 8'h73.
REQ-031 SHALL cover: an exhaustive sweep 0..127 compared against a reference model (value<=99 ? BCD : 8'h99 with ovf=1).
